delay_scan_ctrl: RTL and testbench

Automatic per-link eye-scan and alignment controller for the link deserializer/word-aligner capture path.
- Sweeps the 9-bit IDELAY tap setting in fixed steps.
- At each step: waits for delay lock, requests a word-aligner reset, then dwells while checking alignment and error-count stability.
- Selects the centre of the longest passing run and programs it as the final delay.
- Sits beside each capture instance and drives its delay_in and link_reset_request; an AXI register block drives start and reads the result.

---
 rtl/delay_scan_pkg.sv | 28 ++
 rtl/delay_scan_ctrl_if.sv | 29 ++
 rtl/delay_scan_ctrl_scan_timer.sv | 36 +++
 rtl/delay_scan_ctrl.sv | 221 ++++++++++++++++++++++
 tb/tb_delay_scan_ctrl.sv | 238 +++++++++++++++++++++++
 5 files changed

// File: rtl/delay_scan_pkg.sv
// Shared widths, FSM state encodings and a small sizing helper for the delay scan controller.
package delay_scan_pkg;

    localparam int unsigned TAP_W  = 9;   // IDELAY tap value
    localparam int unsigned STEP_W = 10;  // scan-step counts and 10-bit tap sums
    localparam int unsigned ERR_W  = 8;   // word-aligner error counter
    localparam int unsigned ST_W   = 4;

    localparam logic [ST_W-1:0] ST_IDLE      = 4'd0;
    localparam logic [ST_W-1:0] ST_SET       = 4'd1;
    localparam logic [ST_W-1:0] ST_WAIT_RDY  = 4'd2;
    localparam logic [ST_W-1:0] ST_LRESET    = 4'd3;
    localparam logic [ST_W-1:0] ST_SETTLE    = 4'd4;
    localparam logic [ST_W-1:0] ST_DWELL     = 4'd5;
    localparam logic [ST_W-1:0] ST_EVAL      = 4'd6;
    localparam logic [ST_W-1:0] ST_CENTER    = 4'd7;
    localparam logic [ST_W-1:0] ST_FINAL_RDY = 4'd8;

    // Largest of three cycle counts; sizes the shared wait timer.
    function automatic int unsigned max3(int unsigned a, int unsigned b, int unsigned c);
        int unsigned m;
        m = a;
        if (b > m) m = b;
        if (c > m) m = c;
        return m;
    endfunction

endpackage

// File: rtl/delay_scan_ctrl_if.sv
// Control/status bundle between the scan controller and its deserializer/register block.
interface delay_scan_ctrl_if;
    import delay_scan_pkg::*;

    logic               start;
    logic               delay_ready;
    logic               link_aligned;
    logic [ERR_W-1:0]   link_error_count;
    logic [TAP_W-1:0]   delay_set;
    logic               link_reset_request;
    logic               busy;
    logic               done;
    logic               fail;
    logic [TAP_W-1:0]   best_delay;
    logic [STEP_W-1:0]  eye_width;

    // Controller side
    modport master (
        input  start, delay_ready, link_aligned, link_error_count,
        output delay_set, link_reset_request, busy, done, fail, best_delay, eye_width
    );

    // Deserializer / register-block side
    modport slave (
        output start, delay_ready, link_aligned, link_error_count,
        input  delay_set, link_reset_request, busy, done, fail, best_delay, eye_width
    );

endinterface

// File: rtl/delay_scan_ctrl_scan_timer.sv
// Loadable saturating down-counter shared by every wait state of the scan FSM.
module delay_scan_ctrl_scan_timer #(
    parameter int unsigned CNT_W = 13
) (
    input  logic             clk160,
    input  logic             rstb,
    input  logic             load,
    input  logic [CNT_W-1:0] load_val,
    output logic             expired_c
);

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    // Next count: load wins, otherwise count down and hold at zero
    always_comb begin
        cnt_d = cnt_q;
        if (load) begin
            cnt_d = load_val;
        end else if (cnt_q != '0) begin
            cnt_d = cnt_q - CNT_W'(1);
        end
    end

    // Counter register
    always_ff @(posedge clk160 or negedge rstb) begin
        if (!rstb) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign expired_c = (cnt_q == '0);

endmodule

// File: rtl/delay_scan_ctrl.sv
// Per-link IDELAY eye scan: sweeps taps, scores each point, programs the centre of the widest eye.
module delay_scan_ctrl
    import delay_scan_pkg::*;
#(
    parameter int unsigned DELAY_STEP    = 8,
    parameter int unsigned DELAY_MAX     = 511,
    parameter int unsigned SETTLE_CYCLES = 64,
    parameter int unsigned DWELL_CYCLES  = 4096,
    parameter int unsigned READY_TIMEOUT = 1024
) (
    input  logic               clk160,
    input  logic               rstb,
    delay_scan_ctrl_if.master  bus
);

    localparam int unsigned TIMER_W =
        $clog2(max3(DWELL_CYCLES, READY_TIMEOUT, SETTLE_CYCLES) + 1);

    logic [ST_W-1:0]    state_q, state_d;
    logic [TAP_W-1:0]   cur_q, cur_d;
    logic [STEP_W-1:0]  run_len_q, run_len_d;
    logic [TAP_W-1:0]   run_start_q, run_start_d;
    logic [TAP_W-1:0]   best_start_q, best_start_d;
    logic [ERR_W-1:0]   snap_q, snap_d;
    logic               pass_q, pass_d;
    logic [TAP_W-1:0]   delay_set_q, delay_set_d;
    logic               link_reset_request_q, link_reset_request_d;
    logic               busy_q, busy_d;
    logic               done_q, done_d;
    logic               fail_q, fail_d;
    logic [TAP_W-1:0]   best_delay_q, best_delay_d;
    logic [STEP_W-1:0]  eye_width_q, eye_width_d;

    logic               tmr_load;
    logic [TIMER_W-1:0] tmr_val;
    logic               tmr_expired_c;

    logic [STEP_W-1:0]  next_tap;
    logic [STEP_W-1:0]  run_len_nx;
    logic [TAP_W-1:0]   run_start_nx;
    logic [TAP_W-1:0]   center_tap;

    delay_scan_ctrl_scan_timer #(
        .CNT_W (TIMER_W)
    ) u_scan_timer (
        .clk160    (clk160),
        .rstb      (rstb),
        .load      (tmr_load),
        .load_val  (tmr_val),
        .expired_c (tmr_expired_c)
    );

    // Next tap in 10 bits so the end-of-sweep test never wraps
    assign next_tap     = STEP_W'(cur_q) + STEP_W'(DELAY_STEP);
    // Run tracking for the point just scored
    assign run_len_nx   = pass_q ? (run_len_q + STEP_W'(1)) : '0;
    assign run_start_nx = (pass_q && (run_len_q == '0)) ? cur_q : run_start_q;
    // Centre of the best run; eye_width is non-zero wherever this is used
    assign center_tap   = TAP_W'(32'(best_start_q) +
                                 32'((eye_width_q - STEP_W'(1)) >> 1) * 32'(DELAY_STEP));

    // Next-state and output decode
    always_comb begin
        state_d              = state_q;
        cur_d                = cur_q;
        run_len_d            = run_len_q;
        run_start_d          = run_start_q;
        best_start_d         = best_start_q;
        snap_d               = snap_q;
        pass_d               = pass_q;
        delay_set_d          = delay_set_q;
        link_reset_request_d = 1'b0;
        busy_d               = busy_q;
        done_d               = done_q;
        fail_d               = fail_q;
        best_delay_d         = best_delay_q;
        eye_width_d          = eye_width_q;
        tmr_load             = 1'b0;
        tmr_val              = '0;

        case (state_q)
            ST_IDLE: begin
                if (bus.start) begin
                    done_d      = 1'b0;
                    fail_d      = 1'b0;
                    eye_width_d = '0;
                    busy_d      = 1'b1;
                    cur_d       = '0;
                    run_len_d   = '0;
                    state_d     = ST_SET;
                end
            end
            ST_SET: begin
                delay_set_d = cur_q;
                tmr_load    = 1'b1;
                tmr_val     = TIMER_W'(READY_TIMEOUT - 1);
                state_d     = ST_WAIT_RDY;
            end
            ST_WAIT_RDY: begin
                if (bus.delay_ready) begin
                    state_d = ST_LRESET;
                end else if (tmr_expired_c) begin
                    fail_d  = 1'b1;
                    busy_d  = 1'b0;
                    state_d = ST_IDLE;
                end
            end
            ST_LRESET: begin
                link_reset_request_d = 1'b1;
                tmr_load             = 1'b1;
                tmr_val              = TIMER_W'(SETTLE_CYCLES - 1);
                state_d              = ST_SETTLE;
            end
            ST_SETTLE: begin
                if (tmr_expired_c) begin
                    snap_d   = bus.link_error_count;
                    pass_d   = bus.link_aligned;
                    tmr_load = 1'b1;
                    tmr_val  = TIMER_W'(DWELL_CYCLES - 1);
                    state_d  = ST_DWELL;
                end
            end
            ST_DWELL: begin
                pass_d = pass_q & bus.link_aligned;
                if (tmr_expired_c) begin
                    // Equality, not difference, so a wrapped counter still reads as new errors
                    pass_d  = pass_q & bus.link_aligned & (bus.link_error_count == snap_q);
                    state_d = ST_EVAL;
                end
            end
            ST_EVAL: begin
                run_len_d   = run_len_nx;
                run_start_d = run_start_nx;
                // Strictly greater keeps the earliest of equal-width runs
                if (run_len_nx > eye_width_q) begin
                    eye_width_d  = run_len_nx;
                    best_start_d = run_start_nx;
                end
                if (next_tap > STEP_W'(DELAY_MAX)) begin
                    state_d = ST_CENTER;
                end else begin
                    cur_d   = TAP_W'(next_tap);
                    state_d = ST_SET;
                end
            end
            ST_CENTER: begin
                if (eye_width_q == '0) begin
                    fail_d      = 1'b1;
                    delay_set_d = '0;
                    busy_d      = 1'b0;
                    state_d     = ST_IDLE;
                end else begin
                    best_delay_d = center_tap;
                    delay_set_d  = center_tap;
                    tmr_load     = 1'b1;
                    tmr_val      = TIMER_W'(READY_TIMEOUT - 1);
                    state_d      = ST_FINAL_RDY;
                end
            end
            ST_FINAL_RDY: begin
                if (bus.delay_ready) begin
                    link_reset_request_d = 1'b1;
                    done_d               = 1'b1;
                    busy_d               = 1'b0;
                    state_d              = ST_IDLE;
                end else if (tmr_expired_c) begin
                    fail_d  = 1'b1;
                    busy_d  = 1'b0;
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // State and output registers
    always_ff @(posedge clk160 or negedge rstb) begin
        if (!rstb) begin
            state_q              <= ST_IDLE;
            cur_q                <= '0;
            run_len_q            <= '0;
            run_start_q          <= '0;
            best_start_q         <= '0;
            snap_q               <= '0;
            pass_q               <= 1'b0;
            delay_set_q          <= '0;
            link_reset_request_q <= 1'b0;
            busy_q               <= 1'b0;
            done_q               <= 1'b0;
            fail_q               <= 1'b0;
            best_delay_q         <= '0;
            eye_width_q          <= '0;
        end else begin
            state_q              <= state_d;
            cur_q                <= cur_d;
            run_len_q            <= run_len_d;
            run_start_q          <= run_start_d;
            best_start_q         <= best_start_d;
            snap_q               <= snap_d;
            pass_q               <= pass_d;
            delay_set_q          <= delay_set_d;
            link_reset_request_q <= link_reset_request_d;
            busy_q               <= busy_d;
            done_q               <= done_d;
            fail_q               <= fail_d;
            best_delay_q         <= best_delay_d;
            eye_width_q          <= eye_width_d;
        end
    end

    assign bus.delay_set          = delay_set_q;
    assign bus.link_reset_request = link_reset_request_q;
    assign bus.busy               = busy_q;
    assign bus.done               = done_q;
    assign bus.fail               = fail_q;
    assign bus.best_delay         = best_delay_q;
    assign bus.eye_width          = eye_width_q;

endmodule

// File: tb/tb_delay_scan_ctrl.sv
// Directed bench for delay_scan_ctrl with a small deserializer/word-aligner model.
module tb_delay_scan_ctrl;
    import delay_scan_pkg::*;

    localparam int STEP      = 8;
    localparam int DMAX      = 511;
    localparam int SETTLE    = 4;
    localparam int DWELL     = 16;
    localparam int RT        = 32;
    localparam int READY_LAT = 10;

    logic clk160;
    logic rstb;

    delay_scan_ctrl_if bus_if ();

    delay_scan_ctrl #(
        .DELAY_STEP    (STEP),
        .DELAY_MAX     (DMAX),
        .SETTLE_CYCLES (SETTLE),
        .DWELL_CYCLES  (DWELL),
        .READY_TIMEOUT (RT)
    ) dut (
        .clk160 (clk160),
        .rstb   (rstb),
        .bus    (bus_if)
    );

    initial begin
        clk160 = 1'b0;
        forever #5 clk160 = ~clk160;
    end

    int checks   = 0;
    int failures = 0;

    task automatic check_eq(input string tag, input int got, input int exp);
        checks++;
        if (got != exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // Stimulus-owned model controls
    int rdy_stuck = 0;
    int lo0 = 1000, hi0 = -1, lo1 = 1000, hi1 = -1;
    int err_base  = 0;
    int bump_mark = 0;
    int bump_all  = 0;
    int bump_tap  = -1;
    int lrr_mark  = 0;

    // Model-owned state
    int rdy_cnt    = 0;
    int last_ds    = 0;
    int dw_cnt     = 0;
    int bump_total = 0;
    int lrr_total  = 0;

    // Deserializer model: ready drops on every tap change, passing window, error bumps mid-dwell
    initial begin
        int ds;
        bus_if.delay_ready      = 1'b1;
        bus_if.link_aligned     = 1'b0;
        bus_if.link_error_count = '0;
        forever begin
            @(negedge clk160);
            ds = int'(bus_if.delay_set);
            if (rdy_stuck != 0) begin
                bus_if.delay_ready = 1'b0;
                rdy_cnt = 1;
            end else if (ds != last_ds) begin
                bus_if.delay_ready = 1'b0;
                rdy_cnt = READY_LAT;
            end else if (rdy_cnt > 0) begin
                rdy_cnt--;
                if (rdy_cnt == 0) bus_if.delay_ready = 1'b1;
            end
            last_ds = ds;
            bus_if.link_aligned = ((ds >= lo0 && ds <= hi0) || (ds >= lo1 && ds <= hi1));
            if (bus_if.link_reset_request) begin
                dw_cnt = 1;
                lrr_total++;
            end else if (dw_cnt > 0) begin
                dw_cnt++;
            end
            if (dw_cnt == SETTLE + DWELL / 2 && (bump_all != 0 || ds == bump_tap)) bump_total++;
            bus_if.link_error_count = 8'(err_base + bump_total - bump_mark);
        end
    end

    task automatic pulse_start();
        @(negedge clk160);
        bus_if.start = 1'b1;
        @(negedge clk160);
        bus_if.start = 1'b0;
    endtask

    task automatic wait_idle(input string tag);
        for (int i = 0; i < 20000; i++) begin
            if (!bus_if.busy) break;
            @(negedge clk160);
        end
        check_eq({tag, "_ends"}, int'(bus_if.busy), 0);
        @(negedge clk160);
    endtask

    task automatic run_scan(input string tag);
        lrr_mark = lrr_total;
        pulse_start();
        check_eq({tag, "_busy"}, int'(bus_if.busy), 1);
        wait_idle(tag);
    endtask

    task automatic check_result(input string tag, input int d, input int f,
                                input int ew, input int bd, input int dset);
        check_eq({tag, "_done"},      int'(bus_if.done),       d);
        check_eq({tag, "_fail"},      int'(bus_if.fail),       f);
        check_eq({tag, "_eye_width"}, int'(bus_if.eye_width),  ew);
        check_eq({tag, "_best"},      int'(bus_if.best_delay), bd);
        check_eq({tag, "_delay_set"}, int'(bus_if.delay_set),  dset);
    endtask

    task automatic check_reset_vals(input string tag);
        check_eq({tag, "_delay_set"}, int'(bus_if.delay_set),          0);
        check_eq({tag, "_lrr"},       int'(bus_if.link_reset_request), 0);
        check_eq({tag, "_busy"},      int'(bus_if.busy),               0);
        check_eq({tag, "_done"},      int'(bus_if.done),               0);
        check_eq({tag, "_fail"},      int'(bus_if.fail),               0);
        check_eq({tag, "_best"},      int'(bus_if.best_delay),         0);
        check_eq({tag, "_eye_width"}, int'(bus_if.eye_width),          0);
    endtask

    initial begin
        int found;
        bus_if.start = 1'b0;
        rstb = 1'b1;
        #1 rstb = 1'b0;
        repeat (3) @(negedge clk160);
        check_reset_vals("reset");
        rstb = 1'b1;
        repeat (2) @(negedge clk160);

        // Single window 96..200: taps 96..200 = 14 steps, centre 96 + 6*8
        lo0 = 96; hi0 = 200;
        run_scan("win1");
        check_result("win1", 1, 0, 14, 144, 144);
        check_eq("win1_lrr_pulses", lrr_total - lrr_mark, 65);

        // Two windows: 5 steps then 6 steps (296..336), centre 296 + 2*8
        lo0 = 16; hi0 = 48; lo1 = 296; hi1 = 336;
        run_scan("win2");
        check_result("win2", 1, 0, 6, 312, 312);

        // Equal-width windows: the first one is kept, centre 16 + 2*8
        hi1 = 328;
        run_scan("tie");
        check_result("tie", 1, 0, 5, 32, 32);

        // Aligned everywhere but errors rise at every tap: no eye
        lo0 = 0; hi0 = 511; lo1 = 1000; hi1 = -1;
        bump_mark = bump_total; bump_all = 1;
        run_scan("errs");
        check_result("errs", 0, 1, 0, 32, 0);

        // Counter parked at 255: every point passes, centre 0 + 31*8
        bump_all = 0; err_base = 255; bump_mark = bump_total;
        run_scan("e255");
        check_result("e255", 1, 0, 64, 248, 248);

        // Counter wraps 255->0 at tap 200 only: best run 208..504 (38), centre 208 + 18*8
        bump_mark = bump_total; bump_tap = 200;
        run_scan("wrap");
        check_result("wrap", 1, 0, 38, 352, 352);
        bump_tap = -1; err_base = 0; bump_mark = bump_total;

        // delay_ready stuck low: fail lands RT cycles after the SET tap is driven
        rdy_stuck = 1;
        repeat (2) @(negedge clk160);
        @(negedge clk160);
        bus_if.start = 1'b1;
        @(negedge clk160);
        bus_if.start = 1'b0;
        for (int k = 1; k <= RT + 1; k++) begin
            @(negedge clk160);
            if (k == 3) bus_if.start = 1'b1;
            if (k == 4) bus_if.start = 1'b0;
            if (k == RT)     check_eq("tmo_fail_early", int'(bus_if.fail), 0);
            if (k == RT + 1) begin
                check_eq("tmo_fail", int'(bus_if.fail), 1);
                check_eq("tmo_busy", int'(bus_if.busy), 0);
                check_eq("tmo_done", int'(bus_if.done), 0);
            end
        end
        rdy_stuck = 0;
        repeat (3) @(negedge clk160);

        // Reset during dwell at tap 200, then a clean rescan from tap 0
        lo0 = 96; hi0 = 200;
        pulse_start();
        found = 0;
        for (int i = 0; i < 20000; i++) begin
            @(negedge clk160);
            if (bus_if.link_reset_request && int'(bus_if.delay_set) == 200) begin
                found = 1;
                break;
            end
        end
        check_eq("rst_tap200_seen", found, 1);
        repeat (SETTLE + 3) @(negedge clk160);
        #2 rstb = 1'b0;
        #1 check_reset_vals("midrst");
        @(negedge clk160);
        rstb = 1'b1;
        repeat (2) @(negedge clk160);

        lrr_mark = lrr_total;
        pulse_start();
        found = 0;
        for (int i = 0; i < 2000; i++) begin
            if (bus_if.link_reset_request) begin
                found = 1;
                break;
            end
            @(negedge clk160);
        end
        check_eq("rescan_first_lrr_seen", found, 1);
        check_eq("rescan_first_tap", int'(bus_if.delay_set), 0);
        wait_idle("rescan");
        check_result("rescan", 1, 0, 14, 144, 144);
        check_eq("rescan_lrr_pulses", lrr_total - lrr_mark, 65);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
